video_ram_axil_dp: RTL and testbench

- Parametrised AXI4-Lite slave RAM for the QR reader video path. It is the successor to the fixed 4-register video_ram.
- The AXI4-Lite port is used by the processor to load and read back frame or lookup data.
- A second read-only pixel port lets the video pipeline fetch words concurrently.
- Adds byte strobes, out-of-range error responses, configurable width and depth, and decoupled AW/W acceptance.

---
 rtl/video_ram_axil_dp_if.sv | 37 +++
 rtl/video_ram_axil_dp.sv | 130 +++++++++++++
 tb/tb_video_ram_axil_dp.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_ram_axil_dp_if.sv
// AXI4-Lite channel bundle shared by the video RAM and its processor-side master.
interface video_ram_axil_dp_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/video_ram_axil_dp.sv
// AXI4-Lite RAM with byte strobes and range checking, plus a read-only 1-cycle pixel port.
module video_ram_axil_dp #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 16,
   parameter int unsigned C_MEM_DEPTH        = 1024,
   parameter int unsigned C_PIX_ADDR_WIDTH   = 10
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   video_ram_axil_dp_if.slave            s_axi,
   input  logic                          pix_en,
   input  logic [C_PIX_ADDR_WIDTH-1:0]   pix_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] pix_data,
   output logic                          pix_valid
);
   localparam int unsigned DataW   = C_S_AXI_DATA_WIDTH;
   localparam int unsigned StrbW   = DataW / 8;
   localparam int unsigned AddrLsb = $clog2(StrbW);
   localparam int unsigned IdxW    = C_S_AXI_ADDR_WIDTH - AddrLsb;
   localparam int unsigned MemAw   = $clog2(C_MEM_DEPTH);
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   logic [DataW-1:0] mem [C_MEM_DEPTH];

   logic             aw_held_q, w_held_q, bvalid_q, ar_busy_q, rvalid_q, pix_valid_q;
   logic [IdxW-1:0]  aw_idx_q, ar_idx_q;
   logic [DataW-1:0] w_data_q, rdata_q, pix_data_q;
   logic [StrbW-1:0] w_strb_q;
   logic [1:0]       bresp_q, rresp_q;

   logic             aw_hs, w_hs, ar_hs, commit, rd_go, wr_ok, rd_ok, pix_ok;
   logic [IdxW-1:0]  wr_idx;
   logic [DataW-1:0] wr_data;
   logic [StrbW-1:0] wr_strb;
   logic             unused_bits;

   function automatic logic idx_ok(input logic [IdxW-1:0] idx);
      return 64'(idx) < 64'(C_MEM_DEPTH);
   endfunction

   assign s_axi.awready = !S_AXI_ARESET && !aw_held_q && !bvalid_q;
   assign s_axi.wready  = !S_AXI_ARESET && !w_held_q && !bvalid_q;
   assign s_axi.arready = !S_AXI_ARESET && !ar_busy_q && !rvalid_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;
   assign pix_valid     = pix_valid_q;
   assign pix_data      = pix_data_q;

   assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                          s_axi.awaddr[AddrLsb-1:0], s_axi.araddr[AddrLsb-1:0]};

   always_comb begin
      aw_hs   = s_axi.awvalid && s_axi.awready;
      w_hs    = s_axi.wvalid && s_axi.wready;
      ar_hs   = s_axi.arvalid && s_axi.arready;
      // A channel arriving this cycle bypasses its holding register.
      wr_idx  = aw_held_q ? aw_idx_q : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
      wr_data = w_held_q ? w_data_q : s_axi.wdata;
      wr_strb = w_held_q ? w_strb_q : s_axi.wstrb;
      wr_ok   = idx_ok(wr_idx);
      rd_ok   = idx_ok(ar_idx_q);
      pix_ok  = 64'(pix_addr) < 64'(C_MEM_DEPTH);
      commit  = !S_AXI_ARESET && !bvalid_q && (aw_held_q || aw_hs) && (w_held_q || w_hs);
      // The AXI RAM port is shared; a committing write takes it first.
      rd_go   = !S_AXI_ARESET && ar_busy_q && !commit;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (commit && wr_ok) begin
         for (int b = 0; b < StrbW; b++) begin
            if (wr_strb[b]) mem[MemAw'(wr_idx)][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         ar_busy_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         pix_valid_q <= 1'b0;
         aw_idx_q    <= '0;
         ar_idx_q    <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         rdata_q     <= '0;
         pix_data_q  <= '0;
         bresp_q     <= RespOkay;
         rresp_q     <= RespOkay;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RespOkay : RespSlvErr;
         end
         if (bvalid_q && s_axi.bready) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
         if (ar_hs) begin
            ar_busy_q <= 1'b1;
            ar_idx_q  <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:AddrLsb];
         end
         if (rd_go) begin
            ar_busy_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= rd_ok ? RespOkay : RespSlvErr;
            rdata_q   <= rd_ok ? mem[MemAw'(ar_idx_q)] : '0;
         end
         if (rvalid_q && s_axi.rready) rvalid_q <= 1'b0;
         pix_valid_q <= pix_en;
         if (pix_en) pix_data_q <= pix_ok ? mem[MemAw'(pix_addr)] : '0;
      end
   end
endmodule

// File: tb/tb_video_ram_axil_dp.sv
// Directed plus randomized bench for video_ram_axil_dp against an array-based memory model.
module tb_video_ram_axil_dp;
   localparam int unsigned Depth = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_en = 1'b0;
   logic [9:0]  pix_addr = '0;
   logic [31:0] pix_data;
   logic        pix_valid;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] ref_mem [Depth];

   video_ram_axil_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   video_ram_axil_dp #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(16),
      .C_MEM_DEPTH       (Depth),
      .C_PIX_ADDR_WIDTH  (10)
   ) dut (
      .S_AXI_ACLK  (clk),
      .S_AXI_ARESET(rst),
      .s_axi       (bus.slave),
      .pix_en      (pix_en),
      .pix_addr    (pix_addr),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input int idx);
      return (idx < int'(Depth)) ? ref_mem[idx] : 32'h0;
   endfunction

   function automatic logic [1:0] ref_resp(input int idx);
      return (idx < int'(Depth)) ? 2'b00 : 2'b10;
   endfunction

   task automatic ref_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
      if (idx < int'(Depth)) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic write_check(input string tag, input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_dly, input int w_dly,
                              input int b_dly);
      bit aw_done = 1'b0;
      bit w_done = 1'b0;
      bit go_aw, go_w;
      int n = 0;
      logic [1:0] resp;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!(aw_done && w_done) && n < 50) begin
         bus.awvalid = !aw_done && (n >= aw_dly);
         bus.wvalid  = !w_done && (n >= w_dly);
         if (aw_done) check({tag, " awready held low"}, 64'(bus.awready), 64'(0));
         if (w_done) check({tag, " wready held low"}, 64'(bus.wready), 64'(0));
         go_aw = bus.awvalid && bus.awready;
         go_w  = bus.wvalid && bus.wready;
         step();
         if (go_aw) aw_done = 1'b1;
         if (go_w) w_done = 1'b1;
         n++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      check({tag, " aw/w accepted"}, 64'({aw_done, w_done}), 64'(2'b11));
      n = 0;
      while (!bus.bvalid && n < 20) begin
         step();
         n++;
      end
      check({tag, " bvalid delay"}, 64'(n), 64'(0));
      resp = bus.bresp;
      for (int i = 0; i < b_dly; i++) begin
         step();
         check({tag, " bvalid held"}, 64'(bus.bvalid), 64'(1));
         check({tag, " bresp held"}, 64'(bus.bresp), 64'(resp));
         check({tag, " awready low in B"}, 64'(bus.awready), 64'(0));
         check({tag, " wready low in B"}, 64'(bus.wready), 64'(0));
      end
      check({tag, " bresp"}, 64'(resp), 64'(ref_resp(int'(addr >> 2))));
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;
      check({tag, " bvalid cleared"}, 64'(bus.bvalid), 64'(0));
      ref_write(int'(addr >> 2), data, strb);
   endtask

   task automatic read_check(input string tag, input logic [15:0] addr, input int r_dly);
      int n = 0;
      int lat;
      logic [31:0] first;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      while (!bus.arready && n < 20) begin
         step();
         n++;
      end
      check({tag, " arready"}, 64'(bus.arready), 64'(1));
      step();
      bus.arvalid = 1'b0;
      lat = 1;
      while (!bus.rvalid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, " read latency"}, 64'(lat), 64'(2));
      first = bus.rdata;
      for (int i = 0; i < r_dly; i++) begin
         step();
         check({tag, " rvalid held"}, 64'(bus.rvalid), 64'(1));
         check({tag, " rdata held"}, 64'(bus.rdata), 64'(first));
      end
      check({tag, " rdata"}, 64'(bus.rdata), 64'(ref_read(int'(addr >> 2))));
      check({tag, " rresp"}, 64'(bus.rresp), 64'(ref_resp(int'(addr >> 2))));
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      check({tag, " rvalid cleared"}, 64'(bus.rvalid), 64'(0));
   endtask

   initial begin
      int n;
      int idx;
      logic [31:0] old;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst awready", 64'(bus.awready), 64'(0));
      check("rst wready", 64'(bus.wready), 64'(0));
      check("rst arready", 64'(bus.arready), 64'(0));
      check("rst bvalid", 64'(bus.bvalid), 64'(0));
      check("rst rvalid", 64'(bus.rvalid), 64'(0));
      check("rst bresp", 64'(bus.bresp), 64'(0));
      check("rst rresp", 64'(bus.rresp), 64'(0));
      check("rst rdata", 64'(bus.rdata), 64'(0));
      check("rst pix_valid", 64'(pix_valid), 64'(0));
      check("rst pix_data", 64'(pix_data), 64'(0));
      rst = 1'b0;
      step();
      check("idle awready", 64'(bus.awready), 64'(1));
      check("idle arready", 64'(bus.arready), 64'(1));

      // Sequential write / readback
      for (int i = 0; i < 4; i++) write_check("seq wr", 16'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) read_check("seq rd", 16'(i * 4), 0);

      // Byte strobes
      write_check("strb full", 16'h0010, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      write_check("strb part", 16'h0010, 32'h00001100, 4'h2, 0, 0, 0);
      read_check("strb rd", 16'h0010, 1);
      check("strb value", 64'(ref_read(4)), 64'(32'hAABB11DD));

      // W three cycles ahead of AW, B held off for five cycles
      write_check("decoupled", 16'h0020, 32'hCAFEF00D, 4'hF, 3, 0, 5);
      read_check("decoupled rd", 16'h0020, 0);

      // Out of range
      write_check("oor wr", 16'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      read_check("oor rd", 16'h1000, 0);
      read_check("word0 rd", 16'h0000, 2);

      // Pixel burst
      for (int i = 0; i < 4; i++) begin
         pix_en = 1'b1;
         pix_addr = 10'(i);
         step();
         check("pix valid", 64'(pix_valid), 64'(1));
         check("pix data", 64'(pix_data), 64'(ref_read(i)));
      end
      pix_en = 1'b0;
      step();
      check("pix idle", 64'(pix_valid), 64'(0));

      // Pixel read colliding with an AXI write of the same word
      old = ref_read(2);
      bus.awaddr = 16'h0008; bus.wdata = 32'h55; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      pix_en = 1'b1; pix_addr = 10'd2;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("collide old", 64'(pix_data), 64'(old));
      ref_write(2, 32'h55, 4'hF);
      step();
      check("collide new", 64'(pix_data), 64'(32'h55));
      pix_en = 1'b0;
      check("collide bresp", 64'(bus.bresp), 64'(0));
      bus.bready = 1'b1;
      step();
      bus.bready = 1'b0;

      // Reset the cycle after an AR handshake
      bus.araddr = 16'h0004; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 20) begin
         step();
         n++;
      end
      check("mid arready", 64'(bus.arready), 64'(1));
      step();
      bus.arvalid = 1'b0;
      rst = 1'b1;
      step();
      check("mid rvalid", 64'(bus.rvalid), 64'(0));
      check("mid arready low", 64'(bus.arready), 64'(0));
      check("mid awready low", 64'(bus.awready), 64'(0));
      check("mid wready low", 64'(bus.wready), 64'(0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post rst rvalid", 64'(bus.rvalid), 64'(0));
      end
      read_check("post rst rd", 16'h0004, 0);
      check("retained", 64'(ref_read(1)), 64'(32'h2));

      // Randomized traffic over words 0..63 plus out-of-range addresses
      for (int i = 0; i < 64; i++) write_check("init", 16'(i * 4), $urandom, 4'hF, 0, 0, 0);
      for (int i = 0; i < 150; i++) begin
         idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1024, 16383))
                                            : int'($urandom_range(0, 63));
         case ($urandom_range(0, 2))
            0: write_check("rnd wr", 16'((idx << 2) | int'($urandom_range(0, 3))), $urandom,
                           4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            1: read_check("rnd rd", 16'((idx << 2) | int'($urandom_range(0, 3))),
                          int'($urandom_range(0, 2)));
            default: begin
               for (int k = 0; k < 3; k++) begin
                  idx = int'($urandom_range(0, 63));
                  pix_en = 1'b1;
                  pix_addr = 10'(idx);
                  step();
                  check("rnd pix", 64'(pix_data), 64'(ref_read(idx)));
               end
               pix_en = 1'b0;
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
